// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared state encoding and header constant for the image frame packer
package image_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    function automatic int unsigned image_bytes(input int unsigned width, input int unsigned height);
        return (width * height) / 8;
    endfunction

endpackage

// File: rtl/image_frame_packer_if.sv
// rtl/image_frame_packer_if.sv - start/status and byte stream signals of the image frame packer
interface image_frame_packer_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] image;
    logic         busy;
    logic         done;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    // master: the packer itself, which drives the byte stream and status
    modport master (
        input  start,
        input  image,
        input  tx_ready,
        output busy,
        output done,
        output tx_data,
        output tx_valid
    );

    modport slave (
        output start,
        output image,
        output tx_ready,
        input  busy,
        input  done,
        input  tx_data,
        input  tx_valid
    );
endinterface

// File: rtl/image_frame_packer.sv
// rtl/image_frame_packer.sv - serialises a captured binary image as header + MSB-first bytes
// (+ trailing XOR byte when IMAGE_FRAME_PACKER_CHECKSUM_EN is defined)
module image_frame_packer
    import image_pkg::*;
#(
    parameter int         IMAGE_WIDTH  = 8,
    parameter int         IMAGE_HEIGHT = 4,
    parameter logic [7:0] HEADER       = DEFAULT_HEADER
) (
    input  logic                 clk,
    input  logic                 rst,
    image_frame_packer_if.master bus
);

    localparam int N      = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int NBYTES = int'(image_bytes(IMAGE_WIDTH, IMAGE_HEIGHT));
    localparam int CW     = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    cap_q, cap_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
`endif

    logic            busy_c;
    logic            done_c;
    logic            tx_valid_c;
    logic [7:0]      tx_data_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            cnt_q   <= '0;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Outputs decode from registered state only, so they hold steady while stalled.
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        busy_c     = 1'b0;
        done_c     = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cap_d   = bus.image;
                    cnt_d   = '0;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                busy_c     = 1'b1;
                tx_valid_c = 1'b1;
                tx_data_c  = HEADER;
                if (bus.tx_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                busy_c     = 1'b1;
                tx_valid_c = 1'b1;
                tx_data_c  = cap_q[N-1 -: 8];
                if (bus.tx_ready) begin
                    cap_d = cap_q << 8;
                    cnt_d = cnt_q + CW'(1);
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
                    chk_d = chk_q ^ cap_q[N-1 -: 8];
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
            ST_CHECK: begin
                busy_c     = 1'b1;
                tx_valid_c = 1'b1;
                tx_data_c  = chk_q;
                if (bus.tx_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.tx_valid = tx_valid_c;
    assign bus.tx_data  = tx_data_c;

endmodule

// File: tb/tb_image_frame_packer.sv
// tb/tb_image_frame_packer.sv - self-checking bench for image_frame_packer (default parameters)
module tb_image_frame_packer;

    localparam int NB = 4;
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
    localparam int FB = NB + 2;
`else
    localparam int FB = NB + 1;
`endif

    typedef struct {
        logic [31:0] img;
        logic [47:0] frame;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    vec_t       tbl[4];

    image_frame_packer_if #(.N(32)) bus ();

    image_frame_packer #(
        .IMAGE_WIDTH (8),
        .IMAGE_HEIGHT(4),
        .HEADER      (8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: header, image bytes MSB first, optional XOR of the image bytes.
    task automatic build_exp(input logic [31:0] img);
        logic [7:0] ck = 8'h00;
        logic [7:0] b;
        exp_q = {};
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NB; k++) begin
            b = 8'((img >> (24 - 8 * k)) & 32'hFF);
            exp_q.push_back(b);
            ck = ck ^ b;
        end
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
    endtask

    task automatic cmp_frame(input string nm);
        chk({nm, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("%s_byte%0d", nm, k), (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
    endtask

    task automatic run_frame(input string nm, input logic [31:0] img, input bit rnd,
                             input logic [63:0] stall, input int poke_c);
        int         dn = 0;
        int         lat = -1;
        logic       pstall = 1'b0;
        logic [7:0] pdata = 8'h00;
        got_q = {};
        bus.image = img;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            else     bus.tx_ready = (c < 64) ? ~stall[c] : 1'b1;
            if (c == poke_c) begin
                bus.start = 1'b1;
                bus.image = '1;
            end else if (c == poke_c + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (pstall) begin
                chk({nm, "_hold_valid"}, 64'(bus.tx_valid), 64'(1));
                chk({nm, "_hold_data"}, 64'(bus.tx_data), 64'(pdata));
            end
            if (!rnd && c < 64 && stall[c] && got_q.size() < exp_q.size())
                chk({nm, "_stall_data"}, 64'(bus.tx_data), 64'(exp_q[got_q.size()]));
            pstall = bus.tx_valid && !bus.tx_ready;
            pdata  = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            if (bus.done) begin
                dn++;
                if (lat < 0) lat = c;
            end
            if (lat >= 0 && c >= lat + 3) break;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        cmp_frame(nm);
        chk({nm, "_done_pulses"}, 64'(dn), 64'(1));
        if (!rnd && stall == 64'd0) chk({nm, "_latency"}, 64'(lat), 64'(FB + 1));
        chk({nm, "_idle_busy"}, 64'(bus.busy), 64'(0));
        chk({nm, "_idle_valid"}, 64'(bus.tx_valid), 64'(0));
    endtask

    initial begin
`ifdef IMAGE_FRAME_PACKER_CHECKSUM_EN
        tbl[0] = '{32'h00301800, 48'hA50030180028};
        tbl[1] = '{32'hFFFFFFFF, 48'hA5FFFFFFFF00};
        tbl[2] = '{32'h12345678, 48'hA51234567808};
        tbl[3] = '{32'h80000001, 48'hA58000000181};
`else
        tbl[0] = '{32'h00301800, 48'h00A500301800};
        tbl[1] = '{32'hFFFFFFFF, 48'h00A5FFFFFFFF};
        tbl[2] = '{32'h12345678, 48'h00A512345678};
        tbl[3] = '{32'h80000001, 48'h00A580000001};
`endif
        bus.start    = 1'b0;
        bus.image    = '0;
        bus.tx_ready = 1'b0;

        #3;
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_valid", 64'(bus.tx_valid), 64'(0));
        chk("rst_data", 64'(bus.tx_data), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            exp_q = {};
            for (int k = 0; k < FB; k++) exp_q.push_back(tbl[i].frame[8 * (FB - 1 - k) +: 8]);
            run_frame($sformatf("tbl%0d", i), tbl[i].img, 1'b0, 64'd0, -1);
        end

        build_exp(32'h00301800);
        run_frame("stall", 32'h00301800, 1'b0, 64'h38, -1);

        build_exp(32'h00301800);
        run_frame("ignore_start", 32'h00301800, 1'b0, 64'd0, 3);

        // Reset while the first data byte is on offer.
        build_exp(32'h00301800);
        bus.image    = 32'h00301800;
        bus.start    = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 chk("pre_rst_valid", 64'(bus.tx_valid), 64'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.tx_valid), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy), 64'(0));
        chk("mid_rst_data", 64'(bus.tx_data), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_frame("after_rst", 32'h00301800, 1'b0, 64'd0, -1);

        // Back-to-back frames with start held high.
        begin
            int dn = 0;
            int d1 = -1;
            int d2 = -1;
            int h2 = -1;
            logic [7:0] two_q[$];
            build_exp(32'h12345678);
            two_q = {exp_q, exp_q};
            got_q = {};
            bus.image    = 32'h12345678;
            bus.start    = 1'b1;
            bus.tx_ready = 1'b1;
            @(posedge clk);
            #1;
            for (int c = 1; c <= 100; c++) begin
                @(negedge clk);
                if (bus.tx_valid && bus.tx_ready) begin
                    got_q.push_back(bus.tx_data);
                    if (got_q.size() == FB + 1) h2 = c;
                end
                if (bus.done) begin
                    dn++;
                    if (dn == 1) d1 = c;
                    if (dn == 2) begin
                        d2 = c;
                        bus.start = 1'b0;
                        break;
                    end
                end
                @(posedge clk);
                #1;
            end
            exp_q = two_q;
            cmp_frame("b2b");
            chk("b2b_done1", 64'(d1), 64'(FB + 1));
            chk("b2b_hdr2", 64'(h2), 64'(FB + 3));
            chk("b2b_done2", 64'(d2), 64'(2 * FB + 3));
            repeat (4) @(negedge clk);
            chk("b2b_idle_busy", 64'(bus.busy), 64'(0));
            chk("b2b_idle_valid", 64'(bus.tx_valid), 64'(0));
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] img;
            img = $urandom;
            build_exp(img);
            run_frame($sformatf("rnd%0d", i), img, 1'b1, 64'd0, -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
